mem_issue_arbiter: RTL and testbench

MEM_ISSUE_ARBITER -- requirements
Module: mem_issue_arbiter

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_issue_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_issue_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory issue path.
// Holds the payload field widths used by the arbiter and its neighbours,
// and the load/store priority encoding used by the issue arbiter.
package mem_pkg;

  localparam int OPCODE_W = 5;
  localparam int ADDR_W   = 16;
  localparam int OFFSET_W = 8;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 8;

  // Which requester wins the next contested, non-urgent grant.
  typedef enum logic {
    PRIO_LD = 1'b0,
    PRIO_ST = 1'b1
  } prio_e;

endpackage

// File: rtl/mem_issue_arbiter.sv
// mem_issue_arbiter
// Arbitrates between a load requester and a store requester and issues at
// most one operation per cycle into a single registered output stage that
// feeds memory_pipeline.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   ld_valid / ld_ready               load requester handshake
//   ld_opcode, ld_base, ld_offset, ld_dest     load payload
//   st_valid / st_ready, st_urgent    store handshake; urgent = store queue full
//   st_opcode, st_base, st_offset, st_data     store payload
//   mem_opcode, base_val, offset, dest_reg, data, store   registered payload
//   input_valid / input_ready         handshake into memory_pipeline
//
// Loads and stores alternate when both wait. An urgent store overrides the
// alternation, but only for BURST_MAX consecutive grants while a load is
// waiting, after which the load is guaranteed the next contested slot.
module mem_issue_arbiter
  import mem_pkg::*;
#(
  parameter int BURST_MAX = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [OPCODE_W-1:0] ld_opcode,
  input  logic [ADDR_W-1:0]   ld_base,
  input  logic [OFFSET_W-1:0] ld_offset,
  input  logic [REG_W-1:0]    ld_dest,
  input  logic                st_valid,
  output logic                st_ready,
  input  logic                st_urgent,
  input  logic [OPCODE_W-1:0] st_opcode,
  input  logic [ADDR_W-1:0]   st_base,
  input  logic [OFFSET_W-1:0] st_offset,
  input  logic [DATA_W-1:0]   st_data,
  output logic [OPCODE_W-1:0] mem_opcode,
  output logic [ADDR_W-1:0]   base_val,
  output logic [OFFSET_W-1:0] offset,
  output logic [REG_W-1:0]    dest_reg,
  output logic [DATA_W-1:0]   data,
  output logic                store,
  output logic                input_valid,
  input  logic                input_ready
);

  localparam int BCNT_W = $clog2(BURST_MAX + 1);
  localparam logic [BCNT_W-1:0] BURST_LIMIT = BCNT_W'(BURST_MAX);
  localparam logic [BCNT_W-1:0] BURST_ONE   = BCNT_W'(1'b1);

  prio_e             prio_r;
  logic [BCNT_W-1:0] burst_cnt_r;

  logic load_en_s;
  logic burst_open_s;
  logic grant_ld_s;
  logic grant_st_s;
  logic ld_xfer_s;
  logic st_xfer_s;

  // Grant selection and ready generation. Each port's grant is derived only
  // from the other port's request so that ready never depends on own valid.
  always_comb begin
    load_en_s    = 1'b0;
    burst_open_s = 1'b0;
    grant_ld_s   = 1'b0;
    grant_st_s   = 1'b0;
    ld_ready     = 1'b0;
    st_ready     = 1'b0;
    ld_xfer_s    = 1'b0;
    st_xfer_s    = 1'b0;

    load_en_s    = !input_valid || input_ready;
    burst_open_s = (burst_cnt_r < BURST_LIMIT);

    // Load loses only to a store that is present and either urgent with
    // burst budget left, or non-urgent and holding priority.
    if (!st_valid) begin
      grant_ld_s = 1'b1;
    end else if (st_urgent) begin
      grant_ld_s = !burst_open_s;
    end else begin
      grant_ld_s = (prio_r == PRIO_LD);
    end

    if (!ld_valid) begin
      grant_st_s = 1'b1;
    end else if (st_urgent) begin
      grant_st_s = burst_open_s;
    end else begin
      grant_st_s = (prio_r == PRIO_ST);
    end

    // rst_n gates the readys so nothing is accepted while reset is held.
    ld_ready  = rst_n && load_en_s && grant_ld_s;
    st_ready  = rst_n && load_en_s && grant_st_s;
    ld_xfer_s = ld_valid && ld_ready;
    st_xfer_s = st_valid && st_ready;
  end

  // Output stage: captures the winning payload on a transfer, drops the
  // valid when the stage drains with nothing new, holds during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      input_valid <= 1'b0;
      store       <= 1'b0;
      mem_opcode  <= {OPCODE_W{1'b0}};
      base_val    <= {ADDR_W{1'b0}};
      offset      <= {OFFSET_W{1'b0}};
      dest_reg    <= {REG_W{1'b0}};
      data        <= {DATA_W{1'b0}};
    end else if (ld_xfer_s) begin
      input_valid <= 1'b1;
      store       <= 1'b0;
      mem_opcode  <= ld_opcode;
      base_val    <= ld_base;
      offset      <= ld_offset;
      dest_reg    <= ld_dest;
      data        <= {DATA_W{1'b0}};
    end else if (st_xfer_s) begin
      input_valid <= 1'b1;
      store       <= 1'b1;
      mem_opcode  <= st_opcode;
      base_val    <= st_base;
      offset      <= st_offset;
      dest_reg    <= {REG_W{1'b0}};
      data        <= st_data;
    end else if (load_en_s) begin
      input_valid <= 1'b0;
    end else begin
      input_valid <= input_valid;
    end
  end

  // Priority toggles to the other requester after each transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r <= PRIO_LD;
    end else if (ld_xfer_s) begin
      prio_r <= PRIO_ST;
    end else if (st_xfer_s) begin
      prio_r <= PRIO_LD;
    end else begin
      prio_r <= prio_r;
    end
  end

  // Urgent-store burst counter. An urgent store can only be granted over a
  // waiting load while the count is below the limit, so it cannot overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_r <= {BCNT_W{1'b0}};
    end else if (ld_xfer_s) begin
      burst_cnt_r <= {BCNT_W{1'b0}};
    end else if (st_xfer_s && ld_valid && st_urgent) begin
      burst_cnt_r <= burst_cnt_r + BURST_ONE;
    end else if (load_en_s && !ld_valid) begin
      burst_cnt_r <= {BCNT_W{1'b0}};
    end else begin
      burst_cnt_r <= burst_cnt_r;
    end
  end

endmodule

// File: tb/tb_mem_issue_arbiter.sv
// Self-checking bench for mem_issue_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model
// of the arbitration rules (winner selection, alternation, burst limit).
module tb_mem_issue_arbiter;

  localparam int BMAX = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0, st_valid = 1'b0, st_urgent = 1'b0;
  logic        ld_ready, st_ready;
  logic [4:0]  ld_opcode = '0, st_opcode = '0, ld_dest = '0;
  logic [15:0] ld_base = '0, st_base = '0;
  logic [7:0]  ld_offset = '0, st_offset = '0, st_data = '0;
  logic [4:0]  mem_opcode, dest_reg;
  logic [15:0] base_val;
  logic [7:0]  offset, data;
  logic        store, input_valid;
  logic        input_ready = 1'b0;

  int n_vec = 0;
  int n_miss = 0;

  // Behavioural model state
  bit          m_valid, m_store, m_prio_st;
  int          m_burst;
  logic [4:0]  m_op, m_dest;
  logic [15:0] m_base;
  logic [7:0]  m_off, m_data;

  mem_issue_arbiter #(.BURST_MAX(BMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_opcode(ld_opcode), .ld_base(ld_base), .ld_offset(ld_offset), .ld_dest(ld_dest),
    .st_valid(st_valid), .st_ready(st_ready), .st_urgent(st_urgent),
    .st_opcode(st_opcode), .st_base(st_base), .st_offset(st_offset), .st_data(st_data),
    .mem_opcode(mem_opcode), .base_val(base_val), .offset(offset),
    .dest_reg(dest_reg), .data(data), .store(store),
    .input_valid(input_valid), .input_ready(input_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_valid = 0; m_store = 0; m_prio_st = 0; m_burst = 0;
    m_op = '0; m_dest = '0; m_base = '0; m_off = '0; m_data = '0;
  endtask

  task automatic rand_payload();
    ld_opcode = 5'($urandom); ld_base = 16'($urandom); ld_offset = 8'($urandom);
    ld_dest = 5'($urandom); st_opcode = 5'($urandom); st_base = 16'($urandom);
    st_offset = 8'($urandom); st_data = 8'($urandom);
  endtask

  task automatic chk_outputs();
    chk("input_valid", input_valid, m_valid);
    chk("store", store, m_store);
    chk("mem_opcode", mem_opcode, m_op);
    chk("base_val", base_val, m_base);
    chk("offset", offset, m_off);
    chk("dest_reg", dest_reg, m_dest);
    chk("data", data, m_data);
  endtask

  // Asynchronous reset asserted mid-cycle, released shortly after a rising
  // edge so the very next rising edge can grant.
  task automatic do_reset();
    @(posedge clk);
    #2;
    ld_valid = 1'b1; st_valid = 1'b1; input_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst_ld_ready", ld_ready, 1'b0);
    chk("rst_st_ready", st_ready, 1'b0);
    chk_outputs();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // One cycle: drive at the falling edge, check readys, let the rising edge
  // happen, advance the model, check the output stage.
  task automatic step(input bit lv, input bit sv, input bit su, input bit ir, input bit keep);
    bit stall, ld_win, st_win, lx, sx;
    @(negedge clk);
    ld_valid = lv; st_valid = sv; st_urgent = su; input_ready = ir;
    if (!keep) rand_payload();
    #1;
    stall  = m_valid && !ir;
    ld_win = 0;
    st_win = 0;
    if (lv && sv) begin
      if (su && m_burst < BMAX) st_win = 1;
      else if (su)              ld_win = 1;
      else if (m_prio_st)       st_win = 1;
      else                      ld_win = 1;
    end else begin
      ld_win = lv;
      st_win = sv;
    end
    lx = ld_win && !stall;
    sx = st_win && !stall;
    if (stall) begin
      chk("stall_ld_ready", ld_ready, 1'b0);
      chk("stall_st_ready", st_ready, 1'b0);
    end else begin
      if (lv) chk("ld_ready", ld_ready, lx);
      if (sv) chk("st_ready", st_ready, sx);
    end
    @(posedge clk);
    #1;
    if (lx) begin
      m_valid = 1; m_store = 0; m_op = ld_opcode; m_base = ld_base;
      m_off = ld_offset; m_dest = ld_dest; m_data = '0;
      m_prio_st = 1; m_burst = 0;
    end else if (sx) begin
      m_valid = 1; m_store = 1; m_op = st_opcode; m_base = st_base;
      m_off = st_offset; m_dest = '0; m_data = st_data;
      m_prio_st = 0;
      if (su && lv) m_burst++;
      else if (!lv) m_burst = 0;
    end else if (!stall) begin
      m_valid = 0;
      if (!lv) m_burst = 0;
    end
    chk_outputs();
  endtask

  initial begin
    bit exp29 [4];
    bit exp31 [6];
    exp29 = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp31 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    m_reset();

    // Single load issues with one cycle latency.
    do_reset();
    rand_payload();
    ld_base = 16'h1234; ld_offset = 8'h05; ld_dest = 5'd3;
    step(1, 0, 0, 1, 1);
    chk("lit_valid", input_valid, 1'b1);
    chk("lit_base", base_val, 16'h1234);
    chk("lit_offset", offset, 8'h05);
    chk("lit_dest", dest_reg, 5'd3);
    chk("lit_store", store, 1'b0);

    // Both valid, non-urgent: strict alternation starting with load.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 1, 0);
      chk("lit_alt_store", store, exp29[i]);
    end

    // Output stall holds everything, then the priority holder goes next.
    do_reset();
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    chk("lit_stall_valid", input_valid, 1'b1);
    chk("lit_stall_store", store, 1'b0);
    step(1, 1, 0, 1, 0);
    chk("lit_release_store", store, 1'b1);

    // Urgent burst is capped at BMAX while a load waits.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 1, 1, 0);
      chk("lit_burst_store", store, exp31[i]);
    end

    // Reset in the middle of a stall, then load wins from reset priority.
    do_reset();
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    do_reset();
    step(1, 1, 0, 1, 0);
    chk("lit_post_rst_valid", input_valid, 1'b1);
    chk("lit_post_rst_store", store, 1'b0);
    chk("lit_post_rst_dest", dest_reg, ld_dest);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
             $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 7, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
